slice_unpacker: RTL and testbench

Streaming width-reducing unpacker: accepts IN_W-bit words on a valid/ready input and emits them as IN_W/OUT_W consecutive OUT_W-bit slices on a valid/ready output. It reverses concatenation-style packing (for example, a byte built as {hi_nibble, lo_nibble} goes back out as two nibbles). It sits between wide datapath registers and narrow consumers such as nibble-wide display or serial stages. Throughput is one slice per cycle with no bubbles between words.

---
 rtl/slice_pkg.sv | 24 ++
 rtl/slice_mux.sv | 27 ++
 rtl/slice_unpacker.sv | 94 +++++++++
 tb/tb_slice_unpacker.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/slice_pkg.sv
// Shared types and elaboration-time helpers for the slice packer/unpacker family.
package slice_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int calc_n(input int in_w, input int out_w);
    return (out_w > 0) ? (in_w / out_w) : 0;
  endfunction

  // Index width never drops below one bit so ports stay legal for N==2.
  function automatic int calc_idx_w(input int in_w, input int out_w);
    int n;
    n = calc_n(in_w, out_w);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_ok(input int in_w, input int out_w);
    return (out_w > 0) && (in_w % out_w == 0) && (in_w / out_w >= 2);
  endfunction

endpackage

// File: rtl/slice_mux.sv
// Combinational slice selector: returns slice idx of a held word, MSB- or LSB-first.
// Zero latency; no flow control of its own.
module slice_mux
  import slice_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 4,
  parameter bit MSB_FIRST = 1'b1,
  localparam int N        = calc_n(IN_W, OUT_W),
  localparam int IDX_W    = calc_idx_w(IN_W, OUT_W)
) (
  input  logic [IN_W-1:0]  hold,
  input  logic [IDX_W-1:0] idx,
  output logic [OUT_W-1:0] data
);

  always_comb begin
    data = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == IDX_W'(k)) begin
        if (MSB_FIRST) data = hold[IN_W-1-k*OUT_W -: OUT_W];
        else           data = hold[k*OUT_W +: OUT_W];
      end
    end
  end

endmodule

// File: rtl/slice_unpacker.sv
// Width-reducing unpacker: one IN_W word in, N OUT_W slices out, one slice per cycle.
// Slice 0 appears the cycle after acceptance; in_ready only in IDLE or on the accepted last slice.
module slice_unpacker
  import slice_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 4,
  parameter bit MSB_FIRST = 1'b1,
  localparam int N        = calc_n(IN_W, OUT_W),
  localparam int IDX_W    = calc_idx_w(IN_W, OUT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);

  if (!params_ok(IN_W, OUT_W)) begin : g_bad_params
    $error("slice_unpacker: IN_W must be a multiple of OUT_W giving at least two slices");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t           state;
  logic [IN_W-1:0]  hold;
  logic [IDX_W-1:0] idx;
  logic [OUT_W-1:0] slice;
  logic             in_fire;
  logic             out_fire;

  slice_mux #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_mux (
    .hold (hold),
    .idx  (idx),
    .data (slice)
  );

  assign busy      = (state == SHIFT);
  assign out_valid = busy;
  assign out_idx   = idx;
  assign out_last  = busy && (idx == LAST_IDX);
  assign out_data  = busy ? slice : '0;

  assign out_fire = out_valid && out_ready;
  // The only comb path input-to-output: a new word may enter as the last slice leaves.
  assign in_ready = !rst && ((state == IDLE) || (out_fire && out_last));
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      hold  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            hold  <= in_data;
            idx   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (out_fire) begin
            if (idx != LAST_IDX) begin
              idx <= idx + 1'b1;
            end else if (in_fire) begin
              hold <= in_data;
              idx  <= '0;
            end else begin
              idx   <= '0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slice_unpacker.sv
// Directed bench: cycle table on an 8->4 MSB-first unpacker, plus LSB-first and 16->4 sequences.
module tb_slice_unpacker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8 -> 4, MSB first
  logic [7:0] m_in_data = '0;
  logic       m_in_valid = 1'b0, m_in_ready, m_out_valid, m_out_ready = 1'b1;
  logic [3:0] m_out_data;
  logic [0:0] m_out_idx;
  logic       m_out_last, m_busy;

  // 8 -> 4, LSB first
  logic [7:0] l_in_data = '0;
  logic       l_in_valid = 1'b0, l_in_ready, l_out_valid, l_out_ready = 1'b1;
  logic [3:0] l_out_data;
  logic [0:0] l_out_idx;
  logic       l_out_last, l_busy;

  // 16 -> 4, MSB first
  logic [15:0] w_in_data = '0;
  logic        w_in_valid = 1'b0, w_in_ready, w_out_valid, w_out_ready = 1'b1;
  logic [3:0]  w_out_data;
  logic [1:0]  w_out_idx;
  logic        w_out_last, w_busy;

  slice_unpacker #(.IN_W(8), .OUT_W(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_data(m_in_data), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .out_data(m_out_data), .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_idx(m_out_idx), .out_last(m_out_last), .busy(m_busy));

  slice_unpacker #(.IN_W(8), .OUT_W(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_data(l_in_data), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .out_data(l_out_data), .out_valid(l_out_valid), .out_ready(l_out_ready),
    .out_idx(l_out_idx), .out_last(l_out_last), .busy(l_busy));

  slice_unpacker #(.IN_W(16), .OUT_W(4), .MSB_FIRST(1'b1)) u_wide (
    .clk(clk), .rst(rst), .in_data(w_in_data), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .out_data(w_out_data), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_idx(w_out_idx), .out_last(w_out_last), .busy(w_busy));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       exp_valid;
    logic [3:0] exp_data;
    logic       exp_idx;
    logic       exp_last;
    logic       exp_in_ready;
    logic       exp_busy;
  } vec_t;

  localparam int NV = 27;
  vec_t vt [NV];

  initial begin
    logic [3:0] wide_exp [4];

    // rst  iv  data   ordy  ov  data  idx last inrdy busy
    vt[0]  = '{1, 0, 8'h00, 1,  0, 4'h0, 0, 0, 0, 0};  // in reset
    vt[1]  = '{0, 1, 8'hF5, 1,  0, 4'h0, 0, 0, 1, 0};  // accept F5
    vt[2]  = '{0, 0, 8'h00, 1,  1, 4'hF, 0, 0, 0, 1};
    vt[3]  = '{0, 0, 8'h00, 1,  1, 4'h5, 1, 1, 1, 1};
    vt[4]  = '{0, 0, 8'h00, 1,  0, 4'h0, 0, 0, 1, 0};
    vt[5]  = '{0, 1, 8'hF8, 1,  0, 4'h0, 0, 0, 1, 0};  // back-to-back F8, 08
    vt[6]  = '{0, 1, 8'h08, 1,  1, 4'hF, 0, 0, 0, 1};
    vt[7]  = '{0, 1, 8'h08, 1,  1, 4'h8, 1, 1, 1, 1};
    vt[8]  = '{0, 0, 8'h00, 1,  1, 4'h0, 0, 0, 0, 1};
    vt[9]  = '{0, 0, 8'h00, 1,  1, 4'h8, 1, 1, 1, 1};
    vt[10] = '{0, 1, 8'hA3, 0,  0, 4'h0, 0, 0, 1, 0};  // backpressure on A3
    vt[11] = '{0, 0, 8'h00, 0,  1, 4'hA, 0, 0, 0, 1};
    vt[12] = '{0, 0, 8'h00, 0,  1, 4'hA, 0, 0, 0, 1};
    vt[13] = '{0, 0, 8'h00, 0,  1, 4'hA, 0, 0, 0, 1};
    vt[14] = '{0, 0, 8'h00, 1,  1, 4'hA, 0, 0, 0, 1};
    vt[15] = '{0, 0, 8'h00, 0,  1, 4'h3, 1, 1, 0, 1};
    vt[16] = '{0, 0, 8'h00, 1,  1, 4'h3, 1, 1, 1, 1};
    vt[17] = '{0, 0, 8'h00, 1,  0, 4'h0, 0, 0, 1, 0};
    vt[18] = '{0, 1, 8'h3C, 1,  0, 4'h0, 0, 0, 1, 0};  // reset mid-word on 3C
    vt[19] = '{0, 0, 8'h00, 1,  1, 4'h3, 0, 0, 0, 1};
    vt[20] = '{1, 0, 8'h00, 1,  0, 4'h0, 0, 0, 0, 0};
    vt[21] = '{0, 0, 8'h00, 1,  0, 4'h0, 0, 0, 1, 0};
    vt[22] = '{0, 0, 8'h00, 1,  0, 4'h0, 0, 0, 1, 0};
    vt[23] = '{0, 1, 8'h71, 1,  0, 4'h0, 0, 0, 1, 0};
    vt[24] = '{0, 0, 8'h00, 1,  1, 4'h7, 0, 0, 0, 1};
    vt[25] = '{0, 0, 8'h00, 1,  1, 4'h1, 1, 1, 1, 1};
    vt[26] = '{0, 0, 8'h00, 1,  0, 4'h0, 0, 0, 1, 0};

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst         = vt[i].rst;
      m_in_valid  = vt[i].in_valid;
      m_in_data   = vt[i].in_data;
      m_out_ready = vt[i].out_ready;
      #1;
      chk($sformatf("row%0d out_valid", i), 32'(m_out_valid), 32'(vt[i].exp_valid));
      chk($sformatf("row%0d out_data", i),  32'(m_out_data),  32'(vt[i].exp_data));
      chk($sformatf("row%0d out_idx", i),   32'(m_out_idx),   32'(vt[i].exp_idx));
      chk($sformatf("row%0d out_last", i),  32'(m_out_last),  32'(vt[i].exp_last));
      chk($sformatf("row%0d in_ready", i),  32'(m_in_ready),  32'(vt[i].exp_in_ready));
      chk($sformatf("row%0d busy", i),      32'(m_busy),      32'(vt[i].exp_busy));
    end

    // LSB-first: F5 -> 5, F
    @(negedge clk);
    l_in_valid = 1'b1;
    l_in_data  = 8'hF5;
    #1;
    chk("lsb accept in_ready", 32'(l_in_ready), 32'd1);
    chk("lsb accept out_valid", 32'(l_out_valid), 32'd0);
    @(negedge clk);
    l_in_valid = 1'b0;
    #1;
    chk("lsb s0 valid", 32'(l_out_valid), 32'd1);
    chk("lsb s0 data", 32'(l_out_data), 32'h5);
    chk("lsb s0 last", 32'(l_out_last), 32'd0);
    @(negedge clk);
    #1;
    chk("lsb s1 data", 32'(l_out_data), 32'hF);
    chk("lsb s1 idx", 32'(l_out_idx), 32'd1);
    chk("lsb s1 last", 32'(l_out_last), 32'd1);
    @(negedge clk);
    #1;
    chk("lsb done valid", 32'(l_out_valid), 32'd0);

    // 16 -> 4: ABCD -> A, B, C, D
    wide_exp[0] = 4'hA; wide_exp[1] = 4'hB; wide_exp[2] = 4'hC; wide_exp[3] = 4'hD;
    @(negedge clk);
    w_in_valid = 1'b1;
    w_in_data  = 16'hABCD;
    #1;
    chk("wide accept in_ready", 32'(w_in_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      w_in_valid = 1'b0;
      #1;
      chk($sformatf("wide s%0d valid", k), 32'(w_out_valid), 32'd1);
      chk($sformatf("wide s%0d data", k),  32'(w_out_data),  32'(wide_exp[k]));
      chk($sformatf("wide s%0d idx", k),   32'(w_out_idx),   32'(k));
      chk($sformatf("wide s%0d last", k),  32'(w_out_last),  32'(k == 3));
      chk($sformatf("wide s%0d in_ready", k), 32'(w_in_ready), 32'(k == 3));
    end
    @(negedge clk);
    #1;
    chk("wide done valid", 32'(w_out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
